// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit.
// Moore FSM that sequences the shared datapath (PC, register file, ALU,
// unified memory) over several cycles per instruction. Memory accesses
// wait on mem_ready, and a per-access cycle budget turns a stalled memory
// into a timeout fault instead of a hang. Supports R-type, lw, sw, beq,
// addi and j; any other opcode faults in DECODE.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15  // legal range 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  // Last counter value at which a still-missing mem_ready is tolerated.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_count;
  logic [1:0] r_fault_code;

  state_t     w_next;
  logic       w_is_wait;
  logic       w_timeout;
  logic       w_illegal;

  // Identify memory wait states and detect an expired access budget.
  // mem_ready has priority: a completing access never times out.
  always_comb begin
    w_is_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    w_timeout = w_is_wait && !mem_ready && (r_count == TIMEOUT_LAST);
  end

  // Next-state selection from the current state, opcode and memory handshake.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_FAULT;
        else                w_next = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next    = S_FAULT;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FAULT;
        else                w_next = S_MEMRD;
      end
      S_MEMWB: w_next = S_FETCH;
      S_MEMWR: begin
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
        else                w_next = S_MEMWR;
      end
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_FAULT:  w_next = S_FETCH;
      default:  w_next = S_FETCH;  // unused codes 13-15 recover to FETCH
    endcase
  end

  // State, wait counter and sticky fault code; synchronous reset.
  // The counter is only non-zero while stalled in a wait state, so any
  // entry into a wait state starts from zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state      <= S_FETCH;
      r_count      <= '0;
      r_fault_code <= '0;
    end else begin
      r_state <= w_next;
      if (w_is_wait && !mem_ready && !w_timeout) r_count <= r_count + 8'd1;
      else                                       r_count <= '0;
      if (w_timeout)      r_fault_code <= FC_TIMEOUT;
      else if (w_illegal) r_fault_code <= FC_ILLEGAL;
    end
  end

  // Datapath controls decoded from the state register; strobes are
  // suppressed while reset is high so an abandoned access has no effect.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    fault         = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      mem_read      = 1'b0;
      fault         = 1'b0;
    end
  end

  assign fault_code = r_fault_code;
  assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. Two instances share the
// stimulus: dut uses the default memory timeout, dut_t a short one (4).
// Inputs change 1 time unit after the rising edge, outputs are checked
// on the falling edge.
module tb_multicycle_control;

  // Expected control vectors, bit order:
  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a}_{alu_src_b}_{alu_op}_{pc_source}_{fault}
  localparam logic [16:0] C_RST        = 17'b0000000000_01_00_00_0;
  localparam logic [16:0] C_FETCH_RDY  = 17'b1001010000_01_00_00_0;
  localparam logic [16:0] C_FETCH_WAIT = 17'b0001000000_01_00_00_0;
  localparam logic [16:0] C_DECODE     = 17'b0000000000_11_00_00_0;
  localparam logic [16:0] C_MEMADR     = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] C_MEMRD      = 17'b0011000000_00_00_00_0;
  localparam logic [16:0] C_MEMWB      = 17'b0000001010_00_00_00_0;
  localparam logic [16:0] C_MEMWR      = 17'b0010100000_00_00_00_0;
  localparam logic [16:0] C_MEMWR_RST  = 17'b0010000000_00_00_00_0;
  localparam logic [16:0] C_EXEC       = 17'b0000000001_00_10_00_0;
  localparam logic [16:0] C_ALUWB      = 17'b0000000110_00_00_00_0;
  localparam logic [16:0] C_BRANCH     = 17'b0100000001_00_01_01_0;
  localparam logic [16:0] C_JUMP       = 17'b1000000000_00_00_10_0;
  localparam logic [16:0] C_FAULT      = 17'b0000000000_00_00_00_1;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, fault;
  logic [1:0] alu_src_b, alu_op, pc_source, fault_code;
  logic [3:0] state;

  logic       pc_write_t, pc_write_cond_t, i_or_d_t, mem_read_t, mem_write_t, ir_write_t;
  logic       mem_to_reg_t, reg_dst_t, reg_write_t, alu_src_a_t, fault_t;
  logic [1:0] alu_src_b_t, alu_op_t, pc_source_t, fault_code_t;
  logic [3:0] state_t;

  int n_checks = 0;
  int n_fail   = 0;

  wire [16:0] w_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                        mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                        pc_source, fault};
  wire [16:0] w_ctrl_t = {pc_write_t, pc_write_cond_t, i_or_d_t, mem_read_t, mem_write_t,
                          ir_write_t, mem_to_reg_t, reg_dst_t, reg_write_t, alu_src_a_t,
                          alu_src_b_t, alu_op_t, pc_source_t, fault_t};

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .fault(fault), .fault_code(fault_code), .state(state)
  );

  multicycle_control #(.MEM_TIMEOUT(4)) dut_t (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_t), .pc_write_cond(pc_write_cond_t), .i_or_d(i_or_d_t),
    .mem_read(mem_read_t), .mem_write(mem_write_t), .ir_write(ir_write_t),
    .mem_to_reg(mem_to_reg_t), .reg_dst(reg_dst_t), .reg_write(reg_write_t),
    .alu_src_a(alu_src_a_t), .alu_src_b(alu_src_b_t), .alu_op(alu_op_t),
    .pc_source(pc_source_t), .fault(fault_t), .fault_code(fault_code_t), .state(state_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs and move to the sampling point.
  task automatic drive(input logic [5:0] op, input logic mr, input logic rs);
    opcode    = op;
    mem_ready = mr;
    reset     = rs;
    @(negedge clk);
  endtask

  // One-cycle reset pulse; returns just after the edge with reset low.
  task automatic pulse_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic       rs [7] = '{1, 1, 0, 0, 0, 0, 0};
    logic       mr [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic [3:0] es [7] = '{0, 0, 0, 1, 6, 7, 0};
    logic [16:0] ec [7] = '{C_RST, C_RST, C_FETCH_RDY, C_DECODE, C_EXEC, C_ALUWB, C_FETCH_WAIT};
    for (int i = 0; i < 7; i++) begin
      drive(OP_R, mr[i], rs[i]);
      n_checks++;
      if ({state, w_ctrl, fault_code} !== {es[i], ec[i], 2'b00}) begin
        n_fail++;
        $display("FAIL reset_rtype cyc%0d: got state=%0d ctrl=%b fc=%b, want state=%0d ctrl=%b fc=00",
                 i, state, w_ctrl, fault_code, es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    logic       mr [11] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0};
    logic [3:0] es [11] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
    logic [16:0] ec [11] = '{C_FETCH_WAIT, C_FETCH_WAIT, C_FETCH_WAIT, C_FETCH_RDY, C_DECODE,
                             C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB, C_FETCH_WAIT};
    int ir_pulses = 0;
    pulse_reset();
    for (int i = 0; i < 11; i++) begin
      drive(OP_LW, mr[i], 1'b0);
      if (ir_write) ir_pulses++;
      n_checks++;
      if ({state, w_ctrl, fault_code} !== {es[i], ec[i], 2'b00}) begin
        n_fail++;
        $display("FAIL lw_wait cyc%0d: got state=%0d ctrl=%b fc=%b, want state=%0d ctrl=%b fc=00",
                 i, state, w_ctrl, fault_code, es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (ir_pulses !== 1) begin
      n_fail++;
      $display("FAIL lw_ir_pulses: got %0d, want 1", ir_pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op [11] = '{OP_SW, OP_SW, OP_SW, OP_SW, OP_BEQ, OP_BEQ, OP_BEQ,
                            OP_J, OP_J, OP_J, OP_J};
    logic       mr [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [3:0] es [11] = '{0, 1, 2, 5, 0, 1, 8, 0, 1, 11, 0};
    logic [16:0] ec [11] = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMWR, C_FETCH_RDY, C_DECODE,
                             C_BRANCH, C_FETCH_RDY, C_DECODE, C_JUMP, C_FETCH_WAIT};
    int wr_cycles = 0;
    pulse_reset();
    for (int i = 0; i < 11; i++) begin
      drive(op[i], mr[i], 1'b0);
      if (mem_write) wr_cycles++;
      n_checks++;
      if ({state, w_ctrl} !== {es[i], ec[i]}) begin
        n_fail++;
        $display("FAIL sw_beq_j cyc%0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                 i, state, w_ctrl, es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (wr_cycles !== 1) begin
      n_fail++;
      $display("FAIL sw_write_cycles: got %0d, want 1", wr_cycles);
    end
  endtask

  task automatic test_illegal();
    logic       mr [4] = '{1, 1, 1, 0};
    logic [3:0] es [4] = '{0, 1, 12, 0};
    logic [16:0] ec [4] = '{C_FETCH_RDY, C_DECODE, C_FAULT, C_FETCH_WAIT};
    logic [1:0] fc [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(OP_BAD, mr[i], 1'b0);
      n_checks++;
      if ({state, w_ctrl, fault_code} !== {es[i], ec[i], fc[i]}) begin
        n_fail++;
        $display("FAIL illegal cyc%0d: got state=%0d ctrl=%b fc=%b, want state=%0d ctrl=%b fc=%b",
                 i, state, w_ctrl, fault_code, es[i], ec[i], fc[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Short-timeout instance: four stalled MEMRD cycles fault, while
  // mem_ready on the fourth cycle still completes the load.
  task automatic test_timeout_short();
    logic       mr_a [9] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    logic [3:0] es_a [9] = '{0, 1, 2, 3, 3, 3, 3, 12, 0};
    logic [16:0] ec_a [9] = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD,
                              C_MEMRD, C_FAULT, C_FETCH_WAIT};
    logic [1:0] fc_a [9] = '{0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10};
    logic       mr_b [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 0};
    logic [3:0] es_b [9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    logic [16:0] ec_b [9] = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD,
                              C_MEMRD, C_MEMWB, C_FETCH_WAIT};
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      drive(OP_LW, mr_a[i], 1'b0);
      n_checks++;
      if ({state_t, w_ctrl_t, fault_code_t} !== {es_a[i], ec_a[i], fc_a[i]}) begin
        n_fail++;
        $display("FAIL timeout4 cyc%0d: got state=%0d ctrl=%b fc=%b, want state=%0d ctrl=%b fc=%b",
                 i, state_t, w_ctrl_t, fault_code_t, es_a[i], ec_a[i], fc_a[i]);
      end
      @(posedge clk); #1;
    end
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      drive(OP_LW, mr_b[i], 1'b0);
      n_checks++;
      if ({state_t, w_ctrl_t, fault_code_t} !== {es_b[i], ec_b[i], 2'b00}) begin
        n_fail++;
        $display("FAIL ready_wins cyc%0d: got state=%0d ctrl=%b fc=%b, want state=%0d ctrl=%b fc=00",
                 i, state_t, w_ctrl_t, fault_code_t, es_b[i], ec_b[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Default instance: exactly 15 stalled MEMRD cycles before FAULT.
  task automatic test_timeout_default();
    logic [3:0]  es;
    logic [16:0] ec;
    logic [1:0]  fc;
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      drive(OP_LW, (i < 3), 1'b0);
      if (i == 0)      begin es = 4'd0;  ec = C_FETCH_RDY;  fc = 2'b00; end
      else if (i == 1) begin es = 4'd1;  ec = C_DECODE;     fc = 2'b00; end
      else if (i == 2) begin es = 4'd2;  ec = C_MEMADR;     fc = 2'b00; end
      else if (i < 18) begin es = 4'd3;  ec = C_MEMRD;      fc = 2'b00; end
      else if (i == 18) begin es = 4'd12; ec = C_FAULT;     fc = 2'b10; end
      else             begin es = 4'd0;  ec = C_FETCH_WAIT; fc = 2'b10; end
      n_checks++;
      if ({state, w_ctrl, fault_code} !== {es, ec, fc}) begin
        n_fail++;
        $display("FAIL timeout15 cyc%0d: got state=%0d ctrl=%b fc=%b, want state=%0d ctrl=%b fc=%b",
                 i, state, w_ctrl, fault_code, es, ec, fc);
      end
      @(posedge clk); #1;
    end
  endtask

  // Set fault_code via an illegal opcode, then reset during a stalled sw.
  task automatic test_reset_in_memwr();
    logic [5:0] op [9] = '{OP_BAD, OP_BAD, OP_BAD, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW};
    logic       rs [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic       mr [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [3:0] es [9] = '{0, 1, 12, 0, 1, 2, 5, 5, 0};
    logic [16:0] ec [9] = '{C_FETCH_RDY, C_DECODE, C_FAULT, C_FETCH_RDY, C_DECODE, C_MEMADR,
                            C_MEMWR, C_MEMWR_RST, C_FETCH_WAIT};
    logic [1:0] fc [9] = '{0, 0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      drive(op[i], mr[i], rs[i]);
      n_checks++;
      if ({state, w_ctrl, fault_code} !== {es[i], ec[i], fc[i]}) begin
        n_fail++;
        $display("FAIL reset_memwr cyc%0d: got state=%0d ctrl=%b fc=%b, want state=%0d ctrl=%b fc=%b",
                 i, state, w_ctrl, fault_code, es[i], ec[i], fc[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = OP_R;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_lw_wait();
    test_back_to_back();
    test_illegal();
    test_timeout_short();
    test_timeout_default();
    test_reset_in_memwr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the shared MIPS datapath (IFU/PC, register file, ALU, sign-extend, unified memory) over multiple cycles per instruction.
- Replaces the single-cycle combinational control for the multicycle processor variant.
- Supports R-type, lw, sw, beq, addi and j.
- Handles variable-latency memory via a ready handshake, with a timeout fault.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent waiting on mem_ready in one wait state before faulting; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction register bits [31:26].
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register write data: 0=ALUOut, 1=MDR.
- reg_dst  out  1  destination register: 0=rt, 1=rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A input: 0=PC, 1=A register.
- alu_src_b  out  2  ALU B input: 00=B, 01=const 4, 10=signext imm, 11=signext imm<<2.
- alu_op  out  2  00=add, 01=sub, 10=use funct.
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- fault  out  1  one-cycle pulse in the FAULT state.
- fault_code  out  2  01=illegal opcode, 10=memory timeout; held until next fault or reset.
- state  out  4  current state (debug).

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, FAULT=12; codes 13-15 go to FETCH.
- Outputs decode from the state register. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=00.
  - ir_write and pc_write are asserted only while mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE: src_a=0, src_b=11, alu_op=00. Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - anything else -> FAULT with fault_code=01.
- MEMADR: src_a=1, src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Waits for mem_ready, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Then FETCH.
- MEMWR: mem_write=1, i_or_d=1. Waits for mem_ready, then FETCH.
- EXEC: src_a=1, src_b=00, alu_op=10. Then ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Then FETCH.
- BRANCH: src_a=1, src_b=00, alu_op=01, pc_source=01, pc_write_cond=1. Then FETCH.
- ADDIEX: src_a=1, src_b=10, alu_op=00. Then ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Then FETCH.
- JUMP: pc_source=10, pc_write=1. Then FETCH.
- FAULT: fault=1; then FETCH. The PC is not advanced; software or the bench decides recovery.
- Timeout counter (8 bit):
  - Cleared on entry to any wait state (FETCH, MEMRD, MEMWR) and whenever mem_ready=1.
  - Increments each wait-state cycle with mem_ready=0.
  - When the counter equals MEM_TIMEOUT-1 and mem_ready=0, the next state is FAULT with fault_code=10.
  - No ir_write, pc_write or reg_write results from a timed-out access.
- mem_ready=1 and timeout in the same cycle: mem_ready wins and the access completes.
- Latency with mem_ready always 1 (cycles FETCH to next FETCH): R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
- Reset:
  - The state, counter and fault_code updates below take effect at the clock edge with reset=1: state=FETCH, counter=0, fault_code=00.
  - While reset=1, pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read and fault are forced to 0 combinationally.
  - Reset mid-instruction, including in MEMWR or a wait, abandons the instruction with no further strobes.
- mem_ready is ignored in non-wait states.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1, opcode=000000 -> state sequence 0,1,6,7,0. reg_write=1 with reg_dst=1 only in state 7; all strobes 0 during reset.
- lw (100011) with mem_ready low for 3 cycles in FETCH and 2 in MEMRD -> FETCH held 4 cycles, ir_write/pc_write pulse once. Sequence 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 in state 4.
- sw (101011), then beq (000100), then j (000010), mem_ready=1 -> mem_write=1 with i_or_d=1 for exactly 1 cycle. beq takes 3 cycles with pc_write_cond=1, pc_source=01. j takes 3 cycles with pc_write=1, pc_source=10.
- opcode=111111 in DECODE -> FAULT next cycle, fault=1 for 1 cycle, fault_code=01, then FETCH, no reg_write.
- MEM_TIMEOUT=4, mem_ready held 0 in MEMRD -> FAULT after exactly 4 MEMRD cycles, fault_code=10. Repeat with mem_ready=1 on the 4th cycle -> completes normally to MEMWB.
- reset asserted while in MEMWR with mem_ready=0 -> mem_write=0 that cycle, state=FETCH at next edge, fault_code=00.
